// File: rtl/sram_audio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_audio_arbiter
// Description : Shares one SRAM between the I2S record path (writer) and the
//               I2S playback path (reader). Issues multi-cycle read/write
//               sequences towards the SRAM controller and keeps the record
//               and playback pointers of a circular sample buffer.
// Options     : SRAM_ARB_FULL_GUARD_EN - keep an occupancy count, drop writes
//               into a full buffer (overrun) and return 0 for reads from an
//               empty buffer (underrun).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_audio_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 262144
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_rwb,
  output logic [DATA_W-1:0] sram_write_data,
  input  logic [DATA_W-1:0] sram_read_data,
  output logic              overrun,
  output logic              underrun
);

  // Sequencer states; IDLE is the only state that arbitrates.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SETUP  = 3'd1,
    WR_PULSE  = 3'd2,
    WR_HOLD   = 3'd3,
    RD_SETUP  = 3'd4,
    RD_SAMPLE = 3'd5
  } state_t;

  // Last valid buffer index; pointers wrap from here back to 0.
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(BUF_DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  // 1 = the most recent grant went to the reader, so the writer wins a tie.
  logic              last_grant_rd;

  // Circular-buffer pointer advance.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + ADDR_W'(1);
  endfunction

`ifdef SRAM_ARB_FULL_GUARD_EN
  // Occupancy needs to represent 0..BUF_DEPTH inclusive.
  localparam int              CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

  logic [CNT_W-1:0] count;
  // Latched at the write grant: this write targets a full buffer.
  logic             wr_drop;
`else
  // Without the guard there is no occupancy tracking to report on.
  assign overrun  = 1'b0;
  assign underrun = 1'b0;
`endif

  // Arbitration, access sequencing, pointer bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      sram_rwb        <= 1'b1;
      sram_address    <= '0;
      sram_write_data <= '0;
      rd_data         <= '0;
      wr_ack          <= 1'b0;
      rd_ack          <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      last_grant_rd   <= 1'b1;
`ifdef SRAM_ARB_FULL_GUARD_EN
      count           <= '0;
      wr_drop         <= 1'b0;
      overrun         <= 1'b0;
      underrun        <= 1'b0;
`endif
    end else begin
      // Acks and status flags are single-cycle pulses.
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
`ifdef SRAM_ARB_FULL_GUARD_EN
      overrun  <= 1'b0;
      underrun <= 1'b0;
`endif
      case (state)
        IDLE: begin
          sram_rwb <= 1'b1;
          // Writer wins when alone, or on a tie when the reader went last.
          if (wr_req && (!rd_req || last_grant_rd)) begin
            state           <= WR_SETUP;
            sram_address    <= wr_ptr;
            sram_write_data <= wr_data;
            last_grant_rd   <= 1'b0;
`ifdef SRAM_ARB_FULL_GUARD_EN
            wr_drop         <= (count == CNT_FULL);
`endif
          end else if (rd_req) begin
            state         <= RD_SETUP;
            sram_address  <= rd_ptr;
            last_grant_rd <= 1'b1;
          end
        end

        WR_SETUP: begin
          state <= WR_PULSE;
`ifdef SRAM_ARB_FULL_GUARD_EN
          // A dropped write never strobes the SRAM.
          sram_rwb <= wr_drop;
`else
          sram_rwb <= 1'b0;
`endif
        end

        WR_PULSE: begin
          state    <= WR_HOLD;
          sram_rwb <= 1'b1;
          wr_ack   <= 1'b1;
`ifdef SRAM_ARB_FULL_GUARD_EN
          overrun  <= wr_drop;
`endif
        end

        WR_HOLD: begin
          state    <= IDLE;
          sram_rwb <= 1'b1;
`ifdef SRAM_ARB_FULL_GUARD_EN
          if (!wr_drop) begin
            wr_ptr <= ptr_inc(wr_ptr);
            count  <= count + CNT_W'(1);
          end
`else
          wr_ptr <= ptr_inc(wr_ptr);
`endif
        end

        RD_SETUP: begin
          state    <= RD_SAMPLE;
          sram_rwb <= 1'b1;
          rd_ack   <= 1'b1;
`ifdef SRAM_ARB_FULL_GUARD_EN
          underrun <= (count == '0);
`endif
        end

        RD_SAMPLE: begin
          state    <= IDLE;
          sram_rwb <= 1'b1;
`ifdef SRAM_ARB_FULL_GUARD_EN
          // Empty buffer: hand back silence and leave the read pointer alone.
          if (count == '0) begin
            rd_data <= '0;
          end else begin
            rd_data <= sram_read_data;
            rd_ptr  <= ptr_inc(rd_ptr);
            count   <= count - CNT_W'(1);
          end
`else
          rd_data <= sram_read_data;
          rd_ptr  <= ptr_inc(rd_ptr);
`endif
        end

        default: begin
          state    <= IDLE;
          sram_rwb <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
